fft4_bin_serializer: RTL and testbench

//  Downstream stage of the 4-point radix-4 FFT core (four_fft).
//  - Captures one complete output frame (e/ei, f/fi, g/gi, h/hi) in a single cycle.
//  - Streams the frame out one complex bin per beat, in order bin0=e, bin1=f, bin2=g, bin3=h.
//  - Uses a valid/ready handshake on both sides, so a slow consumer can stall the core's output path.

---
 rtl/fft4_bin_serializer_if.sv | 40 ++++
 rtl/fft4_bin_serializer.sv | 137 +++++++++++++
 tb/tb_fft4_bin_serializer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft4_bin_serializer_if.sv
// Handshake bus for fft4_bin_serializer.
//   Input side : in_valid/in_ready plus the four complex bins e/ei .. h/hi.
//   Output side: out_valid/out_ready, out_re/out_im/out_idx/out_last,
//                and out_mag when FFT4_MAG_EN is defined.
//   master: frame producer and bin consumer (FFT core / testbench).
//   slave : the serializer.
interface fft4_bin_serializer_if #(
  parameter int unsigned DW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] e, ei, f, fi, g, gi, h, hi;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [1:0]    out_idx;
  logic          out_last;
`ifdef FFT4_MAG_EN
  logic [DW:0]   out_mag;

  modport master (
    output in_valid, e, ei, f, fi, g, gi, h, hi, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, out_mag
  );
  modport slave (
    input  in_valid, e, ei, f, fi, g, gi, h, hi, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, out_mag
  );
`else
  modport master (
    output in_valid, e, ei, f, fi, g, gi, h, hi, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
  modport slave (
    input  in_valid, e, ei, f, fi, g, gi, h, hi, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
`endif
endinterface

// File: rtl/fft4_bin_serializer.sv
// Captures a complete 4-point FFT output frame in one cycle and streams it
// out one complex bin per beat (bin0=e .. bin3=h) with valid/ready on both
// sides. A new frame may be captured on the edge bin3 is accepted, giving
// back-to-back frames with no bubble.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        fft4_bin_serializer_if.slave (input frame + output bins)
//   frame_cnt  frames whose bin3 was accepted, wrapping
// Option: define FFT4_MAG_EN to add bus.out_mag = |out_re| + |out_im|.
module fft4_bin_serializer #(
  parameter int unsigned DW  = 4,
  parameter int unsigned FCW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fft4_bin_serializer_if.slave   bus,
  output logic [FCW-1:0]         frame_cnt
);

  localparam int unsigned IDXW = 2;
  localparam logic [IDXW-1:0] LAST_IDX = 2'd3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [7:0][DW-1:0]  frame_q, frame_d;
  logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]       re_q, re_d;
  logic [DW-1:0]       im_q, im_d;
  logic                last_q, last_d;
  logic                in_ready_c;
  logic                capture;
  logic                beat;

`ifdef FFT4_MAG_EN
  logic [DW:0]         mag_q, mag_d;

  // Magnitude of a DW-bit two's complement word; -2^(DW-1) is exact in DW+1 bits.
  function automatic logic [DW:0] abs_w(input logic [DW-1:0] x);
    logic [DW:0] ext;
    ext = {x[DW-1], x};
    abs_w = x[DW-1] ? (~ext + (DW+1)'(1)) : ext;
  endfunction
`endif

  // Next-state, frame capture and output selection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;

    // Ready depends on out_ready only, never on in_valid.
    in_ready_c = (state_q == IDLE) ||
                 ((state_q == SEND) && (idx_q == LAST_IDX) && bus.out_ready);
    capture    = bus.in_valid && in_ready_c;
    beat       = (state_q == SEND) && bus.out_ready;

    if (capture) begin
      frame_d = {bus.hi, bus.h, bus.gi, bus.g, bus.fi, bus.f, bus.ei, bus.e};
    end

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
            idx_d       = '0;
            state_d     = capture ? SEND : IDLE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Pre-select the bin for the next cycle so data leaves straight from flops.
    re_d   = frame_d[{idx_d, 1'b0}];
    im_d   = frame_d[{idx_d, 1'b1}];
    last_d = (state_d == SEND) && (idx_d == LAST_IDX);
`ifdef FFT4_MAG_EN
    mag_d  = abs_w(re_d) + abs_w(im_d);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      re_q        <= '0;
      im_q        <= '0;
      last_q      <= 1'b0;
`ifdef FFT4_MAG_EN
      mag_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      re_q        <= re_d;
      im_q        <= im_d;
      last_q      <= last_d;
`ifdef FFT4_MAG_EN
      mag_q       <= mag_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_idx   = idx_q;
  assign bus.out_re    = re_q;
  assign bus.out_im    = im_q;
  assign bus.out_last  = last_q;
`ifdef FFT4_MAG_EN
  assign bus.out_mag   = mag_q;
`endif
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fft4_bin_serializer.sv
// Directed testbench for fft4_bin_serializer: reset, single frame, stall,
// back-to-back frames, mid-frame reset, magnitude option and counter wrap.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fft4_bin_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] frame_cnt;
  int         checks;
  int         errors;

  fft4_bin_serializer_if #(.DW(4)) bus ();

  fft4_bin_serializer #(.DW(4), .FCW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_frame(input logic [3:0] v0, input logic [3:0] v1,
                           input logic [3:0] v2, input logic [3:0] v3,
                           input logic [3:0] v4, input logic [3:0] v5,
                           input logic [3:0] v6, input logic [3:0] v7);
    bus.e = v0; bus.ei = v1; bus.f = v2; bus.fi = v3;
    bus.g = v4; bus.gi = v5; bus.h = v6; bus.hi = v7;
  endtask

  task automatic expect_beat(input string tag, input int re, input int im,
                             input int idx, input int last);
    check({tag, "_vld"},  32'(bus.out_valid), 1);
    check({tag, "_re"},   32'(bus.out_re),    re);
    check({tag, "_im"},   32'(bus.out_im),    im);
    check({tag, "_idx"},  32'(bus.out_idx),   idx);
    check({tag, "_last"}, 32'(bus.out_last),  last);
  endtask

  task automatic check_mag(input string tag, input int mag);
`ifdef FFT4_MAG_EN
    check({tag, "_mag"}, 32'(bus.out_mag), mag);
`else
    if (tag.len() < 0) $display("%s %0d", tag, mag);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_frame(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    check("rst_vld",  32'(bus.out_valid), 0);
    check("rst_idx",  32'(bus.out_idx),   0);
    check("rst_re",   32'(bus.out_re),    0);
    check("rst_last", 32'(bus.out_last),  0);
    check("rst_cnt",  32'(frame_cnt),     0);
    rst = 1'b0;
    #1 check("rst_rdy", 32'(bus.in_ready), 1);

    // Single frame, consumer always ready
    @(negedge clk);
    set_frame(3, 0, 1, 2, 4, 5, 6, 7);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("t2_rdy", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_frame(15, 15, 15, 15, 15, 15, 15, 15);
    expect_beat("t2b0", 3, 0, 0, 0);
    @(negedge clk);
    expect_beat("t2b1", 1, 2, 1, 0);
    @(negedge clk);
    expect_beat("t2b2", 4, 5, 2, 0);
    @(negedge clk);
    expect_beat("t2b3", 6, 7, 3, 1);
    check("t2_cnt0", 32'(frame_cnt), 0);
    @(negedge clk);
    check("t2_idle", 32'(bus.out_valid), 0);
    check("t2_cnt1", 32'(frame_cnt), 1);

    // Stall at idx 1 for five cycles
    set_frame(1, 2, 3, 4, 5, 6, 7, 8);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_frame(15, 15, 15, 15, 15, 15, 15, 15);
    expect_beat("t3b0", 1, 2, 0, 0);
    @(negedge clk);
    expect_beat("t3b1", 3, 4, 1, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_beat("t3stall", 3, 4, 1, 0);
      check("t3_rdy", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    expect_beat("t3b2", 5, 6, 2, 0);
    @(negedge clk);
    expect_beat("t3b3", 7, 8, 3, 1);
    @(negedge clk);
    check("t3_idle", 32'(bus.out_valid), 0);
    check("t3_cnt",  32'(frame_cnt), 2);
    bus.out_ready = 1'b0;
    #1 check("t3_idle_rdy", 32'(bus.in_ready), 1);

    // Back-to-back frames A then B
    @(negedge clk);
    set_frame(9, 10, 11, 12, 13, 14, 15, 0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    set_frame(2, 3, 4, 5, 6, 7, 8, 9);
    expect_beat("t4a0", 9, 10, 0, 0);
    check("t4_rdy0", 32'(bus.in_ready), 0);
    @(negedge clk);
    expect_beat("t4a1", 11, 12, 1, 0);
    @(negedge clk);
    expect_beat("t4a2", 13, 14, 2, 0);
    @(negedge clk);
    expect_beat("t4a3", 15, 0, 3, 1);
    check("t4_rdy3", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_beat("t4b0", 2, 3, 0, 0);
    check("t4_cnt3", 32'(frame_cnt), 3);
    @(negedge clk);
    expect_beat("t4b1", 4, 5, 1, 0);
    @(negedge clk);
    expect_beat("t4b2", 6, 7, 2, 0);
    @(negedge clk);
    expect_beat("t4b3", 8, 9, 3, 1);
    @(negedge clk);
    check("t4_idle", 32'(bus.out_valid), 0);
    check("t4_cnt4", 32'(frame_cnt), 4);

    // Asynchronous reset during idx 2
    set_frame(1, 1, 2, 2, 3, 3, 4, 4);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_beat("t5b0", 1, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    expect_beat("t5b2", 3, 3, 2, 0);
    #2 rst = 1'b1;
    #1;
    check("t5_vld",  32'(bus.out_valid), 0);
    check("t5_idx",  32'(bus.out_idx),   0);
    check("t5_re",   32'(bus.out_re),    0);
    check("t5_im",   32'(bus.out_im),    0);
    check("t5_last", 32'(bus.out_last),  0);
    check("t5_cnt",  32'(frame_cnt),     0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_nobeat", 32'(bus.out_valid), 0);
    set_frame(5, 6, 7, 8, 9, 10, 11, 12);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_beat("t5n0", 5, 6, 0, 0);
    @(negedge clk);
    expect_beat("t5n1", 7, 8, 1, 0);
    @(negedge clk);
    expect_beat("t5n2", 9, 10, 2, 0);
    @(negedge clk);
    expect_beat("t5n3", 11, 12, 3, 1);
    @(negedge clk);
    check("t5_cnt1", 32'(frame_cnt), 1);

    // Signed extremes (magnitude option)
    set_frame(8, 3, 7, 7, 0, 0, 8, 8);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_beat("t6b0", 8, 3, 0, 0);
    check_mag("t6b0", 11);
    @(negedge clk);
    expect_beat("t6b1", 7, 7, 1, 0);
    check_mag("t6b1", 14);
    @(negedge clk);
    expect_beat("t6b2", 0, 0, 2, 0);
    check_mag("t6b2", 0);
    @(negedge clk);
    expect_beat("t6b3", 8, 8, 3, 1);
    check_mag("t6b3", 16);
    @(negedge clk);
    check("t6_cnt", 32'(frame_cnt), 2);

    // 256 back-to-back frames wrap frame_cnt
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wrap_cnt0", 32'(frame_cnt), 0);
    set_frame(1, 2, 3, 4, 5, 6, 7, 8);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4 * 255 + 1) @(negedge clk);
    check("wrap_cnt255", 32'(frame_cnt), 255);
    repeat (4) @(negedge clk);
    check("wrap_cnt0b", 32'(frame_cnt), 0);
    expect_beat("wrap_b0", 1, 2, 0, 0);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("wrap_idle", 32'(bus.out_valid), 0);
    check("wrap_cnt1", 32'(frame_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
